// File: rtl/pucc_add_pkg.sv
// Shared helpers for the pipelined adder: segment sizing and the signed-overflow rule.
// Imported by add_op_segment and pipelined_add_op.
package pucc_add_pkg;

  // Width of one carry-linked segment; the top level rejects non-integral splits.
  function automatic int seg_width(input int w, input int s);
    return w / s;
  endfunction

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic ovf_flag(input logic lhs_msb, input logic rhs_msb, input logic res_msb);
    return (lhs_msb == rhs_msb) && (res_msb != lhs_msb);
  endfunction

endpackage

// File: rtl/add_op_segment.sv
// One SEG_WIDTH slice of the ripple-segmented adder; purely combinational.
// Zero latency, no flow control of its own.
module add_op_segment
  import pucc_add_pkg::*;
#(
  parameter int SEG_WIDTH = 8
) (
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout
);

  logic [SEG_WIDTH:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
  assign sum   = total[SEG_WIDTH-1:0];
  assign cout  = total[SEG_WIDTH];

endmodule

// File: rtl/pipelined_add_op.sv
// Segmented add, one segment per stage; result valid STAGES cycles after acceptance, full throughput.
// Combinational ready chain stalls without loss; PIPELINED_ADD_OP_SUB_EN adds the sub (lhs - rhs) port.
module pipelined_add_op
  import pucc_add_pkg::*;
#(
  parameter int OPERAND_WIDTH = 32,
  parameter int STAGES        = 4,
  parameter int TAG_WIDTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_WIDTH-1:0] lhs,
  input  logic [OPERAND_WIDTH-1:0] rhs,
  input  logic [TAG_WIDTH-1:0]     in_tag,
`ifdef PIPELINED_ADD_OP_SUB_EN
  input  logic                     sub,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     carry_out,
  output logic                     overflow,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  localparam int W    = OPERAND_WIDTH;
  localparam int SW   = seg_width(OPERAND_WIDTH, STAGES);
  localparam int LAST = STAGES - 1;
  localparam int TW   = TAG_WIDTH;

  if ((OPERAND_WIDTH % STAGES) != 0) begin : g_width_check
    $error("pipelined_add_op: OPERAND_WIDTH must be divisible by STAGES");
  end

  // Unconsumed operand bits are kept right-aligned so every stage adds bits [SW-1:0];
  // partial sums shift in from the top so segment 0 lands at bit 0 after the last stage.
  logic          vld_q [STAGES];
  logic          vld_d [STAGES];
  logic [W-1:0]  opa_q [STAGES];
  logic [W-1:0]  opa_d [STAGES];
  logic [W-1:0]  opb_q [STAGES];
  logic [W-1:0]  opb_d [STAGES];
  logic [W-1:0]  sum_q [STAGES];
  logic [W-1:0]  sum_d [STAGES];
  logic          cy_q  [STAGES];
  logic          cy_d  [STAGES];
  logic [TW-1:0] tag_q [STAGES];
  logic [TW-1:0] tag_d [STAGES];
  logic          ovf_q;
  logic          ovf_d;

  logic          v_x [STAGES];
  logic [W-1:0]  a_x [STAGES];
  logic [W-1:0]  b_x [STAGES];
  logic [W-1:0]  s_x [STAGES];
  logic          c_x [STAGES];
  logic [TW-1:0] t_x [STAGES];

  logic [SW-1:0] seg_sum  [STAGES];
  logic          seg_cout [STAGES];
  logic          adv      [STAGES+1];

  always_comb begin
    v_x[0] = in_valid;
    a_x[0] = lhs;
    s_x[0] = '0;
    t_x[0] = in_tag;
`ifdef PIPELINED_ADD_OP_SUB_EN
    b_x[0] = sub ? ~rhs : rhs;
    c_x[0] = sub;
`else
    b_x[0] = rhs;
    c_x[0] = 1'b0;
`endif
    for (int k = 1; k < STAGES; k++) begin
      v_x[k] = vld_q[k-1];
      a_x[k] = opa_q[k-1];
      b_x[k] = opb_q[k-1];
      s_x[k] = sum_q[k-1];
      c_x[k] = cy_q[k-1];
      t_x[k] = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    add_op_segment #(
      .SEG_WIDTH(SW)
    ) u_seg (
      .a   (a_x[k][SW-1:0]),
      .b   (b_x[k][SW-1:0]),
      .cin (c_x[k]),
      .sum (seg_sum[k]),
      .cout(seg_cout[k])
    );
  end

  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = !vld_q[k] || adv[k+1];
    end

    ovf_d = ovf_q;
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k];
      opa_d[k] = opa_q[k];
      opb_d[k] = opb_q[k];
      sum_d[k] = sum_q[k];
      cy_d[k]  = cy_q[k];
      tag_d[k] = tag_q[k];
      if (adv[k]) begin
        vld_d[k] = v_x[k];
        // Data registers only load real ops so idle outputs keep their last value.
        if (v_x[k]) begin
          opa_d[k] = a_x[k] >> SW;
          opb_d[k] = b_x[k] >> SW;
          sum_d[k] = (s_x[k] >> SW) | (W'(seg_sum[k]) << (W - SW));
          cy_d[k]  = seg_cout[k];
          tag_d[k] = t_x[k];
        end
      end
    end

    // The last segment holds the operand sign bits and the result MSB.
    if (adv[LAST] && v_x[LAST]) begin
      ovf_d = ovf_flag(a_x[LAST][SW-1], b_x[LAST][SW-1], seg_sum[LAST][SW-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
        cy_q[k]  <= 1'b0;
        tag_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
        cy_q[k]  <= cy_d[k];
        tag_q[k] <= tag_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[LAST];
  assign result    = sum_q[LAST];
  assign carry_out = cy_q[LAST];
  assign overflow  = ovf_q;
  assign out_tag   = tag_q[LAST];

endmodule

// File: doc/pipelined_add_op.md
Name: pipelined_add_op

Overview:
- Parametrised, pipelined successor to the combinational add op, for the ALU arith path.
- Splits an OPERAND_WIDTH-bit add into STAGES carry-linked segments, one segment per pipeline stage, so timing scales with width.
- Valid/ready handshake on both sides, full throughput (one op per cycle), back-pressure stalls without loss.
- Outputs carry and signed-overflow flags and passes a tag through for ordering checks.

Parameters:
- OPERAND_WIDTH, 32, operand/result width; must be divisible by STAGES (elaboration error otherwise).
- STAGES, 4, pipeline depth = number of segments; SEG_WIDTH = OPERAND_WIDTH/STAGES; STAGES=1 allowed.
- TAG_WIDTH, 4, width of opaque tag carried alongside each op.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- lhs  in  OPERAND_WIDTH  left operand.
- rhs  in  OPERAND_WIDTH  right operand.
- in_tag  in  TAG_WIDTH  opaque tag.
- sub  in  1  subtract select (present only with PIPELINED_ADD_OP_SUB_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  OPERAND_WIDTH  sum (mod 2^OPERAND_WIDTH).
- carry_out  out  1  carry from MSB (for sub: 1 = no borrow).
- overflow  out  1  signed two's-complement overflow.
- out_tag  out  TAG_WIDTH  tag of this result.

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low clears every stage valid immediately; out_valid=0, result=0, carry_out=0, overflow=0, out_tag=0 during and after reset until first result.
- Stage k (0..STAGES-1) register holds: valid_k, partial sum bits [(k+1)*SEG_WIDTH-1:0], carry into segment k+1, unconsumed upper lhs/rhs segments, sign bits of lhs/rhs, tag.
- Stage 0 adds segment 0 with carry-in 0 (add) or 1 (sub, rhs inverted); stage k adds segment k with carry from stage k-1.
- Final stage drives outputs directly from its register; overflow = (lhs_msb == rhs_eff_msb) && (result_msb != lhs_msb).
- Latency: op accepted at edge N (in_valid && in_ready) appears with out_valid at edge N+STAGES-1, i.e. visible in cycle N+STAGES-1 after acceptance edge; with STAGES=4, accept in cycle 0, out_valid high in cycle 4 -- measured as 4 cycles.
- Advance rule: adv_last = !valid_last || out_ready; adv_k = !valid_k || adv_{k+1}; in_ready = adv_0. Combinational ready chain; no bubbles when out_ready held high.
- Stage k loads from k-1 when adv_k; clears valid_k when adv_k and valid_{k-1}=0.
- Results emerge strictly in acceptance order; none dropped or duplicated.
- Output stable while out_valid && !out_ready.
- in_valid with in_ready low: operands not captured; source must hold.
- Simultaneous accept at input and drain at output when full: both occur same cycle.
- Reset mid-operation: all in-flight ops discarded; none emerge after rst_n deasserts.

Optional Feature:
- Macro PIPELINED_ADD_OP_SUB_EN.
- Defined: sub port present; sub=1 computes lhs - rhs as lhs + ~rhs + 1; sub travels with op for flag logic.
- Undefined: no sub port; add only; carry-in to stage 0 hard-wired 0; no inversion logic.

Decomposition:
- Package pucc_add_pkg: stage record typedef parametrised via localparam helpers, function seg_width(w, s), overflow-compute function.
- One sub-module natural: add_op_segment (SEG_WIDTH adder with carry in/out, combinational); pipelined_add_op instantiates STAGES copies in a generate loop plus registers and ready chain.

Test Plan (OPERAND_WIDTH=32, STAGES=4):
- 0xFFFFFFFF + 0x00000001, out_ready=1 -> result 0x00000000, carry_out=1, overflow=0, out_valid 4 cycles after accept.
- 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry_out=0, overflow=1; tag 0x5 in -> out_tag 0x5.
- 8 back-to-back ops (i + 0x100*i, i=0..7), out_ready=1 -> 8 results on 8 consecutive cycles from cycle 4, in order, in_ready never low.
- out_ready=0 with in_valid held -> exactly 4 ops accepted then in_ready=0; out_ready=1 -> 4 results in order, next op accepted same cycle first drains.
- 3 ops in flight, rst_n pulsed low mid-cycle -> out_valid=0 immediately; no results after release; next op has normal 4-cycle latency.
- (SUB_EN) 5 - 7 -> result 0xFFFFFFFE, carry_out=0; 7 - 5 -> 0x00000002, carry_out=1; 0x80000000 - 1 -> 0x7FFFFFFF, overflow=1.
